// File: rtl/univ_shift_reg.sv
// Universal shift register with hold/load/shift/rotate modes and a counted burst-shift engine.
// Direct mode applies `mode` every edge; a burst applies a captured shift mode for N edges.
module univ_shift_reg #(
    parameter int unsigned     WIDTH     = 8,
    parameter int unsigned     LEN_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in,
    input  logic             start,
    input  logic [LEN_W-1:0] shift_len,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic       ST_IDLE  = 1'b0;
    localparam logic       ST_BURST = 1'b1;

    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROTL = 3'b100;
    localparam logic [2:0] M_ROTR = 3'b101;

    logic             state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bmode_q, bmode_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             so_q, so_d;
    logic             done_q, done_d;

    logic [2:0]       op;
    logic             is_shift;
    logic [WIDTH-1:0] op_q;
    logic             op_so;

    // In BURST the captured mode drives the datapath; live mode is ignored.
    assign op       = (state_q == ST_BURST) ? bmode_q : mode;
    assign is_shift = (mode == M_SHL) || (mode == M_SHR) || (mode == M_ROTL) || (mode == M_ROTR);

    always_comb begin
        op_q  = q_q;
        op_so = so_q;
        case (op)
            M_LOAD: op_q = load_data;
            M_SHL: begin
                op_q  = {q_q[WIDTH-2:0], ser_in};
                op_so = q_q[WIDTH-1];
            end
            M_SHR: begin
                op_q  = {ser_in, q_q[WIDTH-1:1]};
                op_so = q_q[0];
            end
            M_ROTL: begin
                op_q  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                op_so = q_q[WIDTH-1];
            end
            M_ROTR: begin
                op_q  = {q_q[0], q_q[WIDTH-1:1]};
                op_so = q_q[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bmode_d = bmode_q;
        q_d     = q_q;
        so_d    = so_q;
        done_d  = 1'b0;
        if (state_q == ST_BURST) begin
            q_d   = op_q;
            so_d  = op_so;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == LEN_W'(1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end else if (start && is_shift) begin
            // Start edge only captures; the first shift happens on the next edge.
            bmode_d = mode;
            if (shift_len == '0) begin
                done_d = 1'b1;
            end else begin
                state_d = ST_BURST;
                cnt_d   = shift_len;
            end
        end else begin
            q_d  = op_q;
            so_d = op_so;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bmode_q <= '0;
            q_q     <= RESET_VAL;
            so_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bmode_q <= bmode_d;
            q_q     <= q_d;
            so_q    <= so_d;
            done_q  <= done_d;
        end
    end

    assign q       = q_q;
    assign qb      = ~q_q;
    assign ser_out = so_q;
    assign busy    = (state_q == ST_BURST);
    assign done    = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: driver pushes model results, monitor pops and compares.
// Model works on integer arithmetic and a remaining-shift count.
module tb_univ_shift_reg;

    logic       clk;
    logic       rst_n;
    logic [2:0] mode;
    logic [7:0] load_data;
    logic       ser_in;
    logic       start;
    logic [3:0] shift_len;
    logic [7:0] q;
    logic [7:0] qb;
    logic       ser_out;
    logic       busy;
    logic       done;

    univ_shift_reg #(
        .WIDTH    (8),
        .LEN_W    (4),
        .RESET_VAL(8'hA5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .load_data(load_data),
        .ser_in   (ser_in),
        .start    (start),
        .shift_len(shift_len),
        .q        (q),
        .qb       (qb),
        .ser_out  (ser_out),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        int q;
        int so;
        int busy;
        int done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    int mq, mso, rem, kind, mdone;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got == expv) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
    endtask

    // Model op on integers: multiply/divide for shifts, modulo for width.
    task automatic model_op(input int m, input int si, input int ld);
        case (m)
            1: mq = ld;
            2: begin mso = mq / 128; mq = (mq * 2 + si) % 256; end
            3: begin mso = mq % 2;   mq = mq / 2 + si * 128; end
            4: begin mso = mq / 128; mq = (mq * 2) % 256 + mq / 128; end
            5: begin mso = mq % 2;   mq = mq / 2 + (mq % 2) * 128; end
            default: ;
        endcase
    endtask

    task automatic step(input int m, input int ld, input int si, input int st, input int len);
        exp_t e;
        mode      = 3'(m);
        load_data = 8'(ld);
        ser_in    = 1'(si);
        start     = 1'(st);
        shift_len = 4'(len);
        if (rem > 0) begin
            model_op(kind, si, 0);
            rem--;
            mdone = (rem == 0) ? 1 : 0;
        end else if (st != 0 && m >= 2 && m <= 5) begin
            if (len == 0) begin
                mdone = 1;
            end else begin
                rem   = len;
                kind  = m;
                mdone = 0;
            end
        end else begin
            model_op(m, si, ld);
            mdone = 0;
        end
        e.q    = mq;
        e.so   = mso;
        e.busy = (rem > 0) ? 1 : 0;
        e.done = mdone;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Reset between edges; outputs must respond without a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_q", int'(q), 'hA5);
        chk("rst_qb", int'(qb), 'h5A);
        chk("rst_ser_out", int'(ser_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        mq = 'hA5; mso = 0; rem = 0; mdone = 0;
        rst_n = 1'b1;
        #1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("q", int'(q), e.q);
            chk("qb", int'(qb), 255 - e.q);
            chk("ser_out", int'(ser_out), e.so);
            chk("busy", int'(busy), e.busy);
            chk("done", int'(done), e.done);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; mode = '0; load_data = '0; ser_in = 1'b0; start = 1'b0; shift_len = '0;
        mq = 'hA5; mso = 0; rem = 0; kind = 0; mdone = 0;
        #2;
        do_reset();
        step(0, 0, 0, 0, 0);

        // Direct mode: load 81, shl with 1 -> 03, shr with 0 -> 01.
        step(1, 'h81, 0, 0, 0);
        step(2, 0, 1, 0, 0);
        chk("direct_shl", int'(q), 'h03);
        step(3, 0, 0, 0, 0);
        chk("direct_shr", int'(q), 'h01);

        // Burst rotr of 9 on 01 -> 80.
        step(5, 0, 0, 1, 9);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0);
        chk("burst_rotr_q", int'(q), 'h80);
        step(0, 0, 0, 0, 0);

        // Zero-length start.
        step(2, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0);

        // Inputs ignored during burst.
        step(1, 'h0F, 0, 0, 0);
        step(2, 0, 0, 1, 4);
        for (int i = 0; i < 4; i++) step(1, 'hFF, 0, 1, 7);
        chk("ignored_q", int'(q), 'hF0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Reset mid-burst: no done afterwards.
        step(1, 'h3C, 0, 0, 0);
        step(2, 0, 1, 1, 5);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        do_reset();
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);

        // Back-to-back: start presented in the done cycle.
        step(4, 0, 0, 1, 2);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(3, 0, 1, 1, 3);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            int st;
            int len;
            st  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            len = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 15));
            step(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 1)), st, len);
            if ($urandom_range(0, 79) == 0) do_reset();
        end

        step(0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
